// File: rtl/memtest_led_coder_pkg.sv
// Shared state encoding, default timing constants and width helpers for the RAM-test LED coder.
// Constants are used as parameter defaults by the coder and by anything else that shares its timing.
package memtest_led_coder_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_GAP    = 2'd1,
        ST_ON     = 2'd2,
        ST_OFF    = 2'd3
    } state_e;

    localparam int DEF_TICK_DIV  = 240000;
    localparam int DEF_ON_TICKS  = 20;
    localparam int DEF_OFF_TICKS = 30;
    localparam int DEF_GAP_TICKS = 150;
    localparam int DEF_PCW       = 16;
    localparam int ERR_CNT_W     = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A phase timer only needs to reach (ticks-1), so clog2 of the longest phase suffices.
    function automatic int timer_w(input int on_t, input int off_t, input int gap_t);
        int w;
        w = $clog2(max3(on_t, off_t, gap_t));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/memtest_led_coder_tick_gen.sv
// Free-running prescaler: tick_o is high for one clk every DIV clks, first at count DIV-1 after reset.
// Combinational tick from the count register; never restarted except by rst_ni.
module memtest_led_coder_tick_gen #(
    parameter int DIV = 240000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/memtest_led_coder.sv
// Drives the diagnostic LED: pass heartbeat until the first error, then a (bank+1)-flash blink code forever.
// Counters, error latch and LED state all update one clk after the strobe; inputs are never stalled.
module memtest_led_coder
    import memtest_led_coder_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int PCW       = DEF_PCW
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pass_stb_i,
    input  logic                 err_stb_i,
    input  logic [1:0]           err_bank_i,
    output logic                 led_o,
    output logic                 err_flag_o,
    output logic [1:0]           err_bank_q_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [PCW-1:0]       pass_cnt_o
);

    localparam int TW = timer_w(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

    logic                 tick;
    state_e               state_q,    state_d;
    logic [TW-1:0]        timer_q,    timer_d;
    logic [1:0]           flash_q,    flash_d;
    logic                 hb_q,       hb_d;
    logic                 err_flag_q, err_flag_d;
    logic [1:0]           err_bank_q, err_bank_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic [PCW-1:0]       pass_cnt_q, pass_cnt_d;
    logic                 pass_ok;

    memtest_led_coder_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (tick)
    );

    // A pass only counts while the RAM is still clean; a coincident error takes precedence.
    assign pass_ok = pass_stb_i & ~err_stb_i & ~err_flag_q;

    always_comb begin
        err_cnt_d  = err_cnt_q;
        pass_cnt_d = pass_cnt_q;
        hb_d       = hb_q;
        err_flag_d = err_flag_q;
        err_bank_d = err_bank_q;
        if (err_stb_i) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (!err_flag_q) begin
                err_flag_d = 1'b1;
                err_bank_d = err_bank_i;
            end
        end else if (pass_ok) begin
            hb_d = ~hb_q;
            if (pass_cnt_q != '1) begin
                pass_cnt_d = pass_cnt_q + PCW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        flash_d = flash_q;
        led_o   = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                led_o = hb_q;
                if (err_stb_i) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                    flash_d = '0;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (timer_q == GAP_LAST) begin
                        state_d = ST_ON;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_ON: begin
                led_o = 1'b1;
                if (tick) begin
                    if (timer_q == ON_LAST) begin
                        state_d = ST_OFF;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        // flash_q counts flashes already shown minus one; bank n needs n+1 flashes.
                        if (flash_q == err_bank_q) begin
                            state_d = ST_GAP;
                            flash_d = '0;
                        end else begin
                            state_d = ST_ON;
                            flash_d = flash_q + 2'd1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_NORMAL;
            timer_q    <= '0;
            flash_q    <= '0;
            hb_q       <= 1'b0;
            err_flag_q <= 1'b0;
            err_bank_q <= '0;
            err_cnt_q  <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            flash_q    <= flash_d;
            hb_q       <= hb_d;
            err_flag_q <= err_flag_d;
            err_bank_q <= err_bank_d;
            err_cnt_q  <= err_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign err_flag_o   = err_flag_q;
    assign err_bank_q_o = err_bank_q;
    assign err_cnt_o    = err_cnt_q;
    assign pass_cnt_o   = pass_cnt_q;

endmodule

// File: tb/tb_memtest_led_coder.sv
// Randomized bench for memtest_led_coder; the LED reference is derived from tick counts since the first error.
module tb_memtest_led_coder;

    localparam int TICK_DIV = 4;
    localparam int ON       = 2;
    localparam int OFF      = 2;
    localparam int GAP      = 5;
    localparam int PCW      = 4;
    localparam int PMAX     = (1 << PCW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           pass_stb = 1'b0;
    logic           err_stb = 1'b0;
    logic [1:0]     err_bank = 2'd0;
    logic           led;
    logic           err_flag;
    logic [1:0]     err_bank_q;
    logic [7:0]     err_cnt;
    logic [PCW-1:0] pass_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int last_edge;
    int err_edge;
    int m_err_cnt;
    int m_pass_cnt;
    bit m_hb;
    bit m_flag;
    int m_bank;

    memtest_led_coder #(
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF),
        .GAP_TICKS (GAP),
        .PCW       (PCW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pass_stb_i   (pass_stb),
        .err_stb_i    (err_stb),
        .err_bank_i   (err_bank),
        .led_o        (led),
        .err_flag_o   (err_flag),
        .err_bank_q_o (err_bank_q),
        .err_cnt_o    (err_cnt),
        .pass_cnt_o   (pass_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        last_edge++;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pass_stb = 1'b0;
        err_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_err_cnt = 0;
        m_pass_cnt = 0;
        m_hb = 1'b0;
        m_flag = 1'b0;
        m_bank = 0;
        err_edge = 0;
        last_edge = -1;
        rst_n = 1'b1;
    endtask

    // One clk of stimulus plus the reference-model update for that edge.
    task automatic drive(input bit p, input bit e, input logic [1:0] b);
        pass_stb = p;
        err_stb = e;
        err_bank = b;
        step();
        pass_stb = 1'b0;
        err_stb = 1'b0;
        if (e) begin
            if (m_err_cnt < 255) m_err_cnt++;
            if (!m_flag) begin
                m_flag = 1'b1;
                m_bank = int'(b);
                err_edge = last_edge;
            end
        end else if (p && !m_flag) begin
            if (m_pass_cnt < PMAX) m_pass_cnt++;
            m_hb = !m_hb;
        end
    endtask

    // Blink code as a repeating tick pattern: GAP dark, then (bank+1) x (ON lit, OFF dark).
    function automatic bit exp_led();
        int t;
        int p;
        int per;
        if (!m_flag) return m_hb;
        t = (last_edge + 1) / TICK_DIV - (err_edge + 1) / TICK_DIV;
        per = GAP + (m_bank + 1) * (ON + OFF);
        p = t % per;
        return (p >= GAP) && (((p - GAP) % (ON + OFF)) < ON);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({led, err_flag, err_bank_q} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got led=%b flag=%b bank=%0d want 0", led, err_flag, err_bank_q);
        end
        n_checks++;
        if (err_cnt !== 8'd0 || pass_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counts got err=%0d pass=%0d want 0", err_cnt, pass_cnt);
        end
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dut.tick !== (((last_edge + 1) % TICK_DIV) == TICK_DIV - 1)) begin
                n_fail++;
                $display("FAIL reset_tick edge=%0d got %b want %b", last_edge, dut.tick,
                         ((last_edge + 1) % TICK_DIV) == TICK_DIV - 1);
            end
            step();
        end
    endtask

    task automatic test_heartbeat();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0);
            n_checks++;
            if (led !== m_hb) begin
                n_fail++;
                $display("FAIL heartbeat_led pulse=%0d got %b want %b", i, led, m_hb);
            end
            repeat (9) drive(1'b0, 1'b0, 2'd0);
        end
        n_checks++;
        if (pass_cnt !== PCW'(m_pass_cnt)) begin
            n_fail++;
            $display("FAIL heartbeat_cnt got %0d want %0d", pass_cnt, m_pass_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            drive(($urandom % 3) == 0, 1'b0, 2'($urandom));
            n_checks++;
            if (led !== m_hb || pass_cnt !== PCW'(m_pass_cnt)) begin
                n_fail++;
                $display("FAIL heartbeat_rand cyc=%0d got led=%b cnt=%0d want led=%b cnt=%0d",
                         i, led, pass_cnt, m_hb, m_pass_cnt);
            end
        end
    endtask

    task automatic test_code(input logic [1:0] bank);
        apply_reset();
        repeat ($urandom_range(0, 3)) drive(1'b1, 1'b0, 2'd0);
        repeat ($urandom_range(0, 7)) drive(1'b0, 1'b0, 2'd0);
        drive(1'b0, 1'b1, bank);
        n_checks++;
        if (err_flag !== 1'b1 || err_bank_q !== bank || err_cnt !== 8'(m_err_cnt)) begin
            n_fail++;
            $display("FAIL code_latch got flag=%b bank=%0d cnt=%0d want 1 %0d %0d",
                     err_flag, err_bank_q, err_cnt, bank, m_err_cnt);
        end
        for (int i = 0; i < 160; i++) begin
            n_checks++;
            if (led !== exp_led()) begin
                n_fail++;
                $display("FAIL code_led bank=%0d cyc=%0d got %b want %b", bank, i, led, exp_led());
            end
            drive(($urandom % 8) == 0, ($urandom % 16) == 0, 2'($urandom));
        end
        n_checks++;
        if (err_bank_q !== bank || err_cnt !== 8'(m_err_cnt) || pass_cnt !== PCW'(m_pass_cnt)) begin
            n_fail++;
            $display("FAIL code_hold got bank=%0d err=%0d pass=%0d want %0d %0d %0d",
                     err_bank_q, err_cnt, pass_cnt, bank, m_err_cnt, m_pass_cnt);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        repeat (5) drive(1'b1, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 2'd3);
        n_checks++;
        if (pass_cnt !== PCW'(m_pass_cnt) || err_cnt !== 8'(m_err_cnt)) begin
            n_fail++;
            $display("FAIL simul_cnt got pass=%0d err=%0d want %0d %0d",
                     pass_cnt, err_cnt, m_pass_cnt, m_err_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 2'd0);
        end
        n_checks++;
        if (pass_cnt !== PCW'(m_pass_cnt) || led !== exp_led()) begin
            n_fail++;
            $display("FAIL simul_ignore got pass=%0d led=%b want %0d %b",
                     pass_cnt, led, m_pass_cnt, exp_led());
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(1'b0, 1'b1, 2'd1);
        repeat (299) drive(1'b0, 1'b1, 2'($urandom));
        n_checks++;
        if (err_cnt !== 8'(m_err_cnt) || err_bank_q !== 2'(m_bank)) begin
            n_fail++;
            $display("FAIL sat_err got cnt=%0d bank=%0d want %0d %0d", err_cnt, err_bank_q, m_err_cnt, m_bank);
        end
        for (int i = 0; i < 120; i++) begin
            n_checks++;
            if (led !== exp_led()) begin
                n_fail++;
                $display("FAIL sat_led cyc=%0d got %b want %b", i, led, exp_led());
            end
            drive(1'b0, 1'b0, 2'd0);
        end
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 2'd0);
            n_checks++;
            if (pass_cnt !== PCW'(m_pass_cnt) || led !== m_hb) begin
                n_fail++;
                $display("FAIL sat_pass n=%0d got cnt=%0d led=%b want %0d %b",
                         i, pass_cnt, led, m_pass_cnt, m_hb);
            end
        end
    endtask

    task automatic test_reset_mid_flash();
        bit seen;
        apply_reset();
        drive(1'b0, 1'b1, 2'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (led === 1'b1) seen = 1'b1;
            else drive(1'b0, 1'b0, 2'd0);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midrst_wait got no lit LED within 200 clk, want a flash");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 1'b0 || err_flag !== 1'b0 || err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_async got led=%b flag=%b err=%0d want 0 0 0", led, err_flag, err_cnt);
        end
        apply_reset();
        drive(1'b1, 1'b0, 2'd0);
        n_checks++;
        if (led !== m_hb || pass_cnt !== PCW'(m_pass_cnt) || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_normal got led=%b pass=%0d flag=%b want %b %0d 0",
                     led, pass_cnt, err_flag, m_hb, m_pass_cnt);
        end
    endtask

    initial begin
        last_edge = -1;
        err_edge = 0;
        m_err_cnt = 0;
        m_pass_cnt = 0;
        m_hb = 1'b0;
        m_flag = 1'b0;
        m_bank = 0;
        test_reset();
        test_heartbeat();
        test_code(2'd2);
        test_code(2'($urandom));
        test_code(2'd0);
        test_simultaneous();
        test_saturation();
        test_reset_mid_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
